// File: rtl/reg_write_sequencer.sv
// reg_write_sequencer: multi-cycle controller that sequences every register-file
// write of the accumulator processor. It takes one decoded instruction class at a
// time, waits on the memory or input-port handshake when needed, and drives
// one-cycle write strobes to the register write stage.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for start; instruction fields latched on start
// DECODE    | route the latched instruction, detect illegal encodings
// MEM_WAIT  | memory read outstanding (mem_req), bounded by the wait timer
// IN_WAIT   | waiting for input-port data, bounded by the wait timer
// WRITE     | one cycle of write strobes, done pulse, write_count bump
// FAIL      | one cycle done pulse, no strobes, error flags reported
//
// All outputs are registered: next-cycle values are derived from the next state
// so each strobe is visible in exactly the cycle the FSM occupies that state.

module reg_write_sequencer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 16
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [2:0]       op_class_i,
    input  logic [1:0]       dest_sel_i,
    input  logic [1:0]       src_sel_i,
    input  logic             mem_ack_i,
    input  logic             input_valid_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [5:0]       alu_write_signals_o,
    output logic [7:0]       transfer_signals_o,
    output logic             sr_write_o,
    output logic             mem_data_read_o,
    output logic             input_signal_o,
    output logic             mem_req_o,
    output logic             err_illegal_o,
    output logic             err_timeout_o,
    output logic [CNT_W-1:0] write_count_o
);

    localparam logic [2:0] OP_NOP      = 3'd0;
    localparam logic [2:0] OP_ALU      = 3'd1;
    localparam logic [2:0] OP_MEM_ACC  = 3'd2;
    localparam logic [2:0] OP_MEM_SR   = 3'd3;
    localparam logic [2:0] OP_TRANSFER = 3'd4;
    localparam logic [2:0] OP_INPUT    = 3'd5;
    localparam logic [2:0] OP_FLAGS    = 3'd6;
    localparam logic [2:0] OP_ILLEGAL  = 3'd7;

    localparam logic [1:0] REG_ACC = 2'd0;
    localparam logic [1:0] REG_X   = 2'd1;
    localparam logic [1:0] REG_Y   = 2'd2;
    localparam logic [1:0] REG_SP  = 2'd3;

    // The wait timer counts down from TIMEOUT_CYCLES-1; terminal count 0 marks
    // the last wait cycle, so the FSM spends exactly TIMEOUT_CYCLES cycles waiting.
    localparam logic [7:0] WAIT_LOAD = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DECODE   = 3'd1,
        ST_MEM_WAIT = 3'd2,
        ST_IN_WAIT  = 3'd3,
        ST_WRITE    = 3'd4,
        ST_FAIL     = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [1:0] dest_q, dest_d;
    logic [1:0] src_q, src_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [5:0]       alu_q, alu_d;
    logic [7:0]       xfer_q, xfer_d;
    logic             sr_write_q, sr_write_d;
    logic             mem_data_read_q, mem_data_read_d;
    logic             input_signal_q, input_signal_d;
    logic             mem_req_q, mem_req_d;
    logic             err_illegal_q, err_illegal_d;
    logic             err_timeout_q, err_timeout_d;
    logic [CNT_W-1:0] write_count_q, write_count_d;

    logic [7:0] xfer_code;
    logic       xfer_legal;
    logic       illegal_op;
    logic       timeout_hit;
    logic       illegal_hit;

    // Transfer code lookup for the latched src->dest pair; anything not listed is illegal.
    always_comb begin
        xfer_code  = 8'h00;
        xfer_legal = 1'b0;
        unique case ({src_q, dest_q})
            {REG_X, REG_SP}: begin
                xfer_code  = 8'b1000_0100;
                xfer_legal = 1'b1;
            end
            {REG_SP, REG_X}: begin
                xfer_code  = 8'b0100_1000;
                xfer_legal = 1'b1;
            end
            {REG_ACC, REG_Y}: begin
                xfer_code  = 8'b0010_0001;
                xfer_legal = 1'b1;
            end
            {REG_Y, REG_ACC}: begin
                xfer_code  = 8'b0001_0010;
                xfer_legal = 1'b1;
            end
            {REG_ACC, REG_X}: begin
                xfer_code  = 8'b0000_1001;
                xfer_legal = 1'b1;
            end
            {REG_X, REG_ACC}: begin
                xfer_code  = 8'b0000_0110;
                xfer_legal = 1'b1;
            end
            default: begin
                xfer_code  = 8'h00;
                xfer_legal = 1'b0;
            end
        endcase
    end

    // Illegal-instruction detection on the latched fields (input only targets Y).
    always_comb begin
        illegal_op = 1'b0;
        if (op_q == OP_ILLEGAL) begin
            illegal_op = 1'b1;
        end else if ((op_q == OP_TRANSFER) && !xfer_legal) begin
            illegal_op = 1'b1;
        end else if ((op_q == OP_INPUT) && (dest_q != REG_Y)) begin
            illegal_op = 1'b1;
        end
    end

    // Next-state logic, instruction latching and wait timer.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        dest_d      = dest_q;
        src_d       = src_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_hit = 1'b0;
        illegal_hit = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_DECODE;
                    op_d    = op_class_i;
                    dest_d  = dest_sel_i;
                    src_d   = src_sel_i;
                end
            end

            ST_DECODE: begin
                if (illegal_op) begin
                    state_d     = ST_FAIL;
                    illegal_hit = 1'b1;
                end else if ((op_q == OP_MEM_ACC) || (op_q == OP_MEM_SR)) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_LOAD;
                end else if (op_q == OP_INPUT) begin
                    state_d    = ST_IN_WAIT;
                    wait_cnt_d = WAIT_LOAD;
                end else begin
                    state_d = ST_WRITE;
                end
            end

            // An ack on the terminal-count cycle still wins over the timeout.
            ST_MEM_WAIT: begin
                if (mem_ack_i) begin
                    state_d = ST_WRITE;
                end else if (wait_cnt_q == 8'd0) begin
                    state_d     = ST_FAIL;
                    timeout_hit = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 8'd1;
                end
            end

            ST_IN_WAIT: begin
                if (input_valid_i) begin
                    state_d = ST_WRITE;
                end else if (wait_cnt_q == 8'd0) begin
                    state_d     = ST_FAIL;
                    timeout_hit = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 8'd1;
                end
            end

            ST_WRITE: begin
                state_d = ST_IDLE;
            end

            ST_FAIL: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so registered outputs line up with the state.
    always_comb begin
        busy_d          = (state_d != ST_IDLE);
        done_d          = (state_d == ST_WRITE) || (state_d == ST_FAIL);
        alu_d           = 6'b00_0000;
        xfer_d          = 8'h00;
        sr_write_d      = 1'b0;
        mem_data_read_d = 1'b0;
        input_signal_d  = 1'b0;
        mem_req_d       = 1'b0;
        err_illegal_d   = illegal_hit;
        err_timeout_d   = err_timeout_q | timeout_hit;
        write_count_d   = write_count_q;

        unique case (state_d)
            ST_MEM_WAIT: begin
                mem_req_d       = 1'b1;
                mem_data_read_d = 1'b1;
            end

            ST_IN_WAIT: begin
                input_signal_d = 1'b1;
            end

            ST_WRITE: begin
                write_count_d = write_count_q + CNT_W'(1);
                unique case (op_q)
                    OP_ALU: begin
                        unique case (dest_q)
                            REG_ACC: alu_d = 6'b01_0001;
                            REG_X:   alu_d = 6'b01_0010;
                            REG_Y:   alu_d = 6'b01_0100;
                            default: alu_d = 6'b01_1000;
                        endcase
                    end
                    OP_MEM_ACC: begin
                        alu_d           = 6'b00_0001;
                        mem_data_read_d = 1'b1;
                    end
                    OP_MEM_SR: begin
                        sr_write_d      = 1'b1;
                        mem_data_read_d = 1'b1;
                    end
                    OP_TRANSFER: begin
                        xfer_d = xfer_code;
                    end
                    OP_INPUT: begin
                        input_signal_d = 1'b1;
                        alu_d          = 6'b00_0100;
                    end
                    OP_FLAGS: begin
                        sr_write_d = 1'b1;
                    end
                    default: begin
                        alu_d = 6'b00_0000;
                    end
                endcase
            end

            default: begin
                alu_d = 6'b00_0000;
            end
        endcase
    end

    // State, latched instruction, timer and output registers; reset aborts everything.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q         <= ST_IDLE;
            op_q            <= OP_NOP;
            dest_q          <= REG_ACC;
            src_q           <= REG_ACC;
            wait_cnt_q      <= 8'd0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            alu_q           <= 6'b00_0000;
            xfer_q          <= 8'h00;
            sr_write_q      <= 1'b0;
            mem_data_read_q <= 1'b0;
            input_signal_q  <= 1'b0;
            mem_req_q       <= 1'b0;
            err_illegal_q   <= 1'b0;
            err_timeout_q   <= 1'b0;
            write_count_q   <= '0;
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            dest_q          <= dest_d;
            src_q           <= src_d;
            wait_cnt_q      <= wait_cnt_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            alu_q           <= alu_d;
            xfer_q          <= xfer_d;
            sr_write_q      <= sr_write_d;
            mem_data_read_q <= mem_data_read_d;
            input_signal_q  <= input_signal_d;
            mem_req_q       <= mem_req_d;
            err_illegal_q   <= err_illegal_d;
            err_timeout_q   <= err_timeout_d;
            write_count_q   <= write_count_d;
        end
    end

    assign busy_o              = busy_q;
    assign done_o              = done_q;
    assign alu_write_signals_o = alu_q;
    assign transfer_signals_o  = xfer_q;
    assign sr_write_o          = sr_write_q;
    assign mem_data_read_o     = mem_data_read_q;
    assign input_signal_o      = input_signal_q;
    assign mem_req_o           = mem_req_q;
    assign err_illegal_o       = err_illegal_q;
    assign err_timeout_o       = err_timeout_q;
    assign write_count_o       = write_count_q;

endmodule

// File: tb/tb_reg_write_sequencer.sv
// Testbench for reg_write_sequencer: directed scenarios plus randomized
// instructions, compared cycle by cycle against a transaction-level model.

module tb_reg_write_sequencer;

    localparam int TMO   = 16;
    localparam int CNT_W = 16;

    logic             clock;
    logic             reset;
    logic             start;
    logic [2:0]       op_class;
    logic [1:0]       dest_sel;
    logic [1:0]       src_sel;
    logic             mem_ack;
    logic             input_valid;
    logic             busy;
    logic             done;
    logic [5:0]       alu_write_signals;
    logic [7:0]       transfer_signals;
    logic             sr_write;
    logic             mem_data_read;
    logic             input_signal;
    logic             mem_req;
    logic             err_illegal;
    logic             err_timeout;
    logic [CNT_W-1:0] write_count;

    int n_checks = 0;
    int n_errors = 0;

    // model state
    int       exp_count = 0;
    bit       exp_eto   = 1'b0;
    bit [7:0] xfer_tab [16];
    bit       xfer_ok  [16];

    reg_write_sequencer #(
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (CNT_W)
    ) dut (
        .clock_i            (clock),
        .reset_i            (reset),
        .start_i            (start),
        .op_class_i         (op_class),
        .dest_sel_i         (dest_sel),
        .src_sel_i          (src_sel),
        .mem_ack_i          (mem_ack),
        .input_valid_i      (input_valid),
        .busy_o             (busy),
        .done_o             (done),
        .alu_write_signals_o(alu_write_signals),
        .transfer_signals_o (transfer_signals),
        .sr_write_o         (sr_write),
        .mem_data_read_o    (mem_data_read),
        .input_signal_o     (input_signal),
        .mem_req_o          (mem_req),
        .err_illegal_o      (err_illegal),
        .err_timeout_o      (err_timeout),
        .write_count_o      (write_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input bit bsy, input bit dn, input logic [5:0] alu,
                                         input logic [7:0] xf, input bit sr, input bit mdr,
                                         input bit ins, input bit mrq, input bit eill,
                                         input bit eto);
        return {10'd0, bsy, dn, alu, xf, sr, mdr, ins, mrq, eill, eto};
    endfunction

    function automatic logic [31:0] observed();
        return {10'd0, busy, done, alu_write_signals, transfer_signals, sr_write,
                mem_data_read, input_signal, mem_req, err_illegal, err_timeout};
    endfunction

    // Expected write-cycle strobes for a legal instruction.
    function automatic logic [31:0] write_vec(input int op, input int dst, input int src);
        logic [5:0] alu = 6'd0;
        logic [7:0] xf  = 8'd0;
        bit sr = 0, mdr = 0, ins = 0;
        case (op)
            1: alu = 6'(16 + (1 << dst));
            2: begin alu = 6'd1; mdr = 1; end
            3: begin sr = 1; mdr = 1; end
            4: xf = xfer_tab[src*4 + dst];
            5: begin ins = 1; alu = 6'd4; end
            6: sr = 1;
            default: ;
        endcase
        return pack(1, 1, alu, xf, sr, mdr, ins, 0, 0, exp_eto);
    endfunction

    // One instruction from IDLE back to IDLE. ack_at: wait cycle (1-based) in which
    // the handshake is presented; 0 means never. Must be called at a negedge in IDLE.
    task automatic issue(input int op, input int dst, input int src, input int ack_at,
                         input bit hold_start);
        bit illegal, mem_w, in_w, timed_out, acked;
        illegal   = (op == 7) || (op == 4 && !xfer_ok[src*4 + dst]) || (op == 5 && dst != 2);
        mem_w     = !illegal && (op == 2 || op == 3);
        in_w      = !illegal && (op == 5);
        timed_out = 0;
        acked     = 0;

        start    = 1'b1;
        op_class = 3'(op);
        dest_sel = 2'(dst);
        src_sel  = 2'(src);
        @(negedge clock);
        check_val("decode", observed(), pack(1, 0, 0, 0, 0, 0, 0, 0, 0, exp_eto));
        if (!hold_start) start = 1'b0;
        op_class    = 3'($urandom);
        dest_sel    = 2'($urandom);
        src_sel     = 2'($urandom);
        mem_ack     = 1'($urandom);
        input_valid = 1'($urandom);

        if (mem_w || in_w) begin
            for (int i = 1; i <= TMO && !acked; i++) begin
                @(negedge clock);
                if (mem_w) begin
                    check_val("mem_wait", observed(), pack(1, 0, 0, 0, 0, 1, 0, 1, 0, exp_eto));
                    mem_ack     = (i == ack_at);
                    input_valid = 1'($urandom);
                end else begin
                    check_val("in_wait", observed(), pack(1, 0, 0, 0, 0, 0, 1, 0, 0, exp_eto));
                    input_valid = (i == ack_at);
                    mem_ack     = 1'($urandom);
                end
                if (i == ack_at) acked = 1;
                else if (i == TMO) timed_out = 1;
            end
        end

        @(negedge clock);
        start       = 1'b0;
        mem_ack     = 1'($urandom);
        input_valid = 1'($urandom);
        if (illegal || timed_out) begin
            if (timed_out) exp_eto = 1'b1;
            check_val("fail", observed(), pack(1, 1, 0, 0, 0, 0, 0, 0, illegal, exp_eto));
        end else begin
            exp_count = (exp_count + 1) % (1 << CNT_W);
            check_val("write", observed(), write_vec(op, dst, src));
        end

        @(negedge clock);
        check_val("idle", observed(), pack(0, 0, 0, 0, 0, 0, 0, 0, 0, exp_eto));
        check_val("count", 32'(write_count), 32'(exp_count));
        mem_ack     = 1'b0;
        input_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            xfer_tab[i] = 8'h00;
            xfer_ok[i]  = 1'b0;
        end
        // index = src*4 + dst
        xfer_tab[1*4 + 3] = 8'b1000_0100; xfer_ok[1*4 + 3] = 1;
        xfer_tab[3*4 + 1] = 8'b0100_1000; xfer_ok[3*4 + 1] = 1;
        xfer_tab[0*4 + 2] = 8'b0010_0001; xfer_ok[0*4 + 2] = 1;
        xfer_tab[2*4 + 0] = 8'b0001_0010; xfer_ok[2*4 + 0] = 1;
        xfer_tab[0*4 + 1] = 8'b0000_1001; xfer_ok[0*4 + 1] = 1;
        xfer_tab[1*4 + 0] = 8'b0000_0110; xfer_ok[1*4 + 0] = 1;

        reset       = 1'b1;
        start       = 1'b1;
        op_class    = 3'd1;
        dest_sel    = 2'd0;
        src_sel     = 2'd0;
        mem_ack     = 1'b0;
        input_valid = 1'b0;
        repeat (3) @(negedge clock);
        check_val("reset_out", observed(), 32'd0);
        check_val("reset_count", 32'(write_count), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clock);

        issue(1, 2, 0, 0, 0);           // ALU -> Y
        issue(2, 0, 0, 3, 0);           // MEM_ACC, ack in third wait cycle
        issue(5, 2, 0, 0, 0);           // INPUT, never valid -> timeout
        for (int s = 0; s < 4; s++)
            for (int d = 0; d < 4; d++)
                issue(4, d, s, 0, 0);   // every transfer pair
        issue(2, 1, 3, 5, 1);           // start held during MEM_WAIT

        // reset in the middle of MEM_WAIT
        start    = 1'b1;
        op_class = 3'd2;
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        check_val("pre_reset_wait", observed(), pack(1, 0, 0, 0, 0, 1, 0, 1, 0, exp_eto));
        reset = 1'b1;
        start = 1'b0;
        @(negedge clock);
        check_val("mid_reset_out", observed(), 32'd0);
        check_val("mid_reset_count", 32'(write_count), 32'd0);
        reset     = 1'b0;
        exp_count = 0;
        exp_eto   = 1'b0;
        @(negedge clock);

        issue(3, 0, 0, TMO, 0);         // MEM_SR, ack on the timeout cycle
        issue(6, 3, 1, 0, 0);           // FLAGS
        issue(0, 1, 2, 0, 0);           // NOP
        issue(5, 1, 0, 2, 0);           // INPUT to X is illegal

        for (int n = 0; n < 80; n++) begin
            int op, dst, src, ack;
            op  = int'($urandom_range(0, 7));
            dst = int'($urandom_range(0, 3));
            src = int'($urandom_range(0, 3));
            if (op == 5 && $urandom_range(0, 3) != 0) dst = 2;
            ack = int'($urandom_range(0, TMO));
            if (ack == 0 && $urandom_range(0, 2) != 0) ack = 1;
            issue(op, dst, src, ack, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg_write_sequencer.md
Name: reg_write_sequencer

Overview:
- Multi-cycle control FSM that sequences every register-file write in the accumulator processor.
- Accepts one decoded instruction class at a time and handles the memory-read and input-port handshakes.
- Emits one-cycle write-control strobes to the register write stage: ALU write vector, transfer code, status-register write, memory-data select, input select.
- Sits between the instruction decoder and the register write stage. Also reports completion, illegal-op and timeout errors.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles spent in MEM_WAIT or IN_WAIT before abort. Legal range 1..255.
- CNT_W, 16: width of the retired-write counter.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  issue pulse; sampled only in IDLE
- op_class  in  3  0 NOP, 1 ALU, 2 MEM_ACC, 3 MEM_SR, 4 TRANSFER, 5 INPUT, 6 FLAGS, 7 illegal
- dest_sel  in  2  register id: 0 Acc, 1 X, 2 Y, 3 SP
- src_sel  in  2  register id, used by TRANSFER only
- mem_ack  in  1  memory data valid
- input_valid  in  1  input port data valid
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- alu_write_signals  out  6  bit4 ALURead, bit3 SPWrite, bit2 YWrite, bit1 XWrite, bit0 AccWrite, bit5 always 0
- transfer_signals  out  8  transfer code, else 0
- sr_write  out  1  status register write
- mem_data_read  out  1  memory-data select
- input_signal  out  1  input-port select
- mem_req  out  1  memory read request
- err_illegal  out  1  one-cycle pulse with done for an illegal op
- err_timeout  out  1  sticky until reset
- write_count  out  CNT_W  count of WRITE states entered, wraps at 2^CNT_W

Behaviour:
- Registered outputs; all outputs 0 after any clock edge with reset=1. Reset dominates start, aborts any state, drops mem_req, clears err_timeout and write_count.
- States: IDLE, DECODE, MEM_WAIT, IN_WAIT, WRITE, FAIL. op_class, dest_sel and src_sel are latched on the edge where start=1 in IDLE.
- start is ignored while busy; no queueing.
- IDLE -> DECODE on start.
- DECODE routes as follows:
  - ALU, TRANSFER, FLAGS, NOP: -> WRITE.
  - MEM_ACC, MEM_SR: -> MEM_WAIT.
  - INPUT: -> IN_WAIT.
  - op 7, an illegal transfer pair, or INPUT with dest≠Y: -> FAIL.
- Latency: start at edge k gives WRITE/FAIL visible in cycle k+2 for non-handshake ops; IDLE again in cycle k+3.
- MEM_WAIT:
  - mem_req=1 and mem_data_read=1.
  - mem_ack sampled 1 -> WRITE on the next cycle.
  - Wait counter resets on entry and increments per cycle. At TIMEOUT_CYCLES without ack -> FAIL and err_timeout is set.
- IN_WAIT: input_signal=1. input_valid -> WRITE. Same timeout rule as MEM_WAIT.
- WRITE (exactly one cycle): done=1, write_count+1, then -> IDLE. Strobes per op:
  - ALU: alu_write_signals = 010001 (Acc), 010010 (X), 010100 (Y), 011000 (SP) per dest_sel.
  - MEM_ACC: alu_write_signals=000001, mem_data_read=1.
  - MEM_SR: sr_write=1, mem_data_read=1.
  - TRANSFER (src->dst):
    - X->SP 10000100
    - SP->X 01001000
    - Acc->Y 00100001
    - Y->Acc 00010010
    - Acc->X 00001001
    - X->Acc 00000110
    - Any other pair, including src=dst, is illegal.
  - INPUT: input_signal=1, alu_write_signals=000100.
  - FLAGS: sr_write=1, mem_data_read=0.
  - NOP: all strobes 0; done=1 and counter still increments.
- FAIL (one cycle): done=1, all strobes 0, err_illegal=1 only for the illegal cause, then -> IDLE.
- Every strobe is 0 outside WRITE, except mem_req/mem_data_read in MEM_WAIT and input_signal in IN_WAIT.
- mem_ack or input_valid arriving in any state other than its wait state is ignored.
- Ack arriving in the same cycle the counter reaches the limit: the ack wins, giving WRITE with no error.

Test Plan:
- Reset, then start with op=1, dest=2 -> cycle k+2: alu_write_signals=010100, done=1, busy=1; cycle k+3: busy=0, write_count=1.
- op=2 with mem_ack raised 3 cycles after MEM_WAIT entry -> mem_req high 3 cycles; WRITE has alu_write_signals=000001, mem_data_read=1.
- op=5, dest=2, input_valid never asserted, TIMEOUT_CYCLES=16 -> input_signal high 16 cycles; FAIL: done=1, err_timeout=1 and stays 1; no strobes.
- All 16 TRANSFER src/dst pairs -> six legal pairs emit the listed codes; the other ten give err_illegal=1 pulse with done and transfer_signals=0.
- start held high continuously during MEM_WAIT -> no re-issue until IDLE; reset asserted mid-MEM_WAIT -> next cycle mem_req=0, busy=0, write_count=0.
- op=3 with mem_ack on the timeout cycle -> WRITE with sr_write=1, mem_data_read=1, err_timeout=0.
